ysyx_25040111_clint_timer: RTL

AXI4-Lite single-beat machine-timer slave at `DEV_CLINT`. It sits directly downstream of the LSU and serves its CLINT-range loads and stores. It holds the 64-bit mtime counter and the 64-bit mtimecmp register, and drives a registered timer interrupt to the core. It is a read/write replacement for the current read-only CLINT path.

---
 rtl/ysyx_25040111_clint_timer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040111_clint_timer.sv
// AXI4-Lite machine-timer slave: 64-bit mtime/mtimecmp with registered timer_irq.
// Optional CLINT_MTIME_LATCH_EN: a read of mtime lo snapshots mtime hi for a consistent 64-bit read.
module ysyx_25040111_clint_timer #(
  parameter int unsigned DIV  = 1,
  parameter logic [31:0] BASE = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        timer_irq
);

  typedef enum logic [2:0] {REG_CMP_LO, REG_CMP_HI, REG_MT_LO, REG_MT_HI, REG_NONE} reg_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;

  localparam logic [31:0] PRESC_MAX = 32'(DIV - 1);

  function automatic reg_e decode(input logic [13:0] off);
    case (off)
      14'h1000: decode = REG_CMP_LO;
      14'h1001: decode = REG_CMP_HI;
      14'h2FFE: decode = REG_MT_LO;
      14'h2FFF: decode = REG_MT_HI;
      default:  decode = REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    merge = old;
    for (int unsigned i = 0; i < 4; i++)
      if (strb[i]) merge[8*i +: 8] = data[8*i +: 8];
  endfunction

  logic [63:0] mtime, mtimecmp, mtime_nx, cmp_nx;
  logic [31:0] presc;
  logic        tick;
  rstate_e     rstate;
  wstate_e     wstate;
  logic        aw_got, w_got, aw_fire, w_fire, wr_go;
  logic [13:0] aw_q, wr_off;
  logic [31:0] wd_q, wr_data, rd_val;
  logic [3:0]  ws_q, wr_strb;
  reg_e        wr_sel, rd_sel;
`ifdef CLINT_MTIME_LATCH_EN
  logic [31:0] mtime_shadow;
`endif

  logic unused_bits;
  assign unused_bits = ^{araddr[31:16], araddr[1:0], awaddr[31:16], awaddr[1:0], BASE};

  always_comb begin
    tick    = (presc == PRESC_MAX);
    aw_fire = awvalid & awready;
    w_fire  = wvalid & wready;
    wr_off  = aw_got ? aw_q : awaddr[15:2];
    wr_data = w_got ? wd_q : wdata;
    wr_strb = w_got ? ws_q : wstrb;
    wr_go   = (wstate == W_IDLE) & (aw_got | aw_fire) & (w_got | w_fire);
    wr_sel  = decode(wr_off);
    rd_sel  = decode(araddr[15:2]);
  end

  // A write to either mtime half suppresses that cycle's increment entirely.
  always_comb begin
    mtime_nx = tick ? mtime + 64'd1 : mtime;
    cmp_nx   = mtimecmp;
    if (wr_go) begin
      case (wr_sel)
        REG_CMP_LO: cmp_nx   = {mtimecmp[63:32], merge(mtimecmp[31:0], wr_data, wr_strb)};
        REG_CMP_HI: cmp_nx   = {merge(mtimecmp[63:32], wr_data, wr_strb), mtimecmp[31:0]};
        REG_MT_LO:  mtime_nx = {mtime[63:32], merge(mtime[31:0], wr_data, wr_strb)};
        REG_MT_HI:  mtime_nx = {merge(mtime[63:32], wr_data, wr_strb), mtime[31:0]};
        default: ;
      endcase
    end
  end

  always_comb begin
    case (rd_sel)
      REG_CMP_LO: rd_val = mtimecmp[31:0];
      REG_CMP_HI: rd_val = mtimecmp[63:32];
      REG_MT_LO:  rd_val = mtime[31:0];
`ifdef CLINT_MTIME_LATCH_EN
      REG_MT_HI:  rd_val = mtime_shadow;
`else
      REG_MT_HI:  rd_val = mtime[63:32];
`endif
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc     <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + 32'd1;
      mtime     <= mtime_nx;
      mtimecmp  <= cmp_nx;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate  <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
`ifdef CLINT_MTIME_LATCH_EN
      mtime_shadow <= '0;
`endif
    end else begin
      case (rstate)
        R_IDLE: if (arvalid) begin
          rdata   <= rd_val;
          rresp   <= (rd_sel == REG_NONE) ? 2'b10 : 2'b00;
          rvalid  <= 1'b1;
          arready <= 1'b0;
          rstate  <= R_RESP;
`ifdef CLINT_MTIME_LATCH_EN
          if (rd_sel == REG_MT_LO) mtime_shadow <= mtime[63:32];
`endif
        end
        R_RESP: if (rready) begin
          rvalid  <= 1'b0;
          arready <= 1'b1;
          rstate  <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate  <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b1;
      bvalid  <= 1'b0;
      bresp   <= '0;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      aw_q    <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (wr_go) begin
            bvalid  <= 1'b1;
            bresp   <= (wr_sel == REG_NONE) ? 2'b10 : 2'b00;
            awready <= 1'b0;
            wready  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            wstate  <= W_RESP;
          end else begin
            if (aw_fire) begin
              aw_got  <= 1'b1;
              aw_q    <= awaddr[15:2];
              awready <= 1'b0;
            end
            if (w_fire) begin
              w_got  <= 1'b1;
              wd_q   <= wdata;
              ws_q   <= wstrb;
              wready <= 1'b0;
            end
          end
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          wready  <= 1'b1;
          wstate  <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule
